// File: rtl/comparator_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
// Result encoding is one-hot, ordered {equal, less, greater}.
package comparator_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CMP  = 1'b1
  } state_t;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;

endpackage

// File: rtl/cmp_bit_slice.sv
// Single-bit compare stage: reports whether the bits differ and whether A wins.
// invert_sense flips the winner for the sign bit of a two's-complement compare.
module cmp_bit_slice (
  input  logic a_bit,
  input  logic b_bit,
  input  logic invert_sense,
  output logic differ,
  output logic a_gt
);

  assign differ = a_bit ^ b_bit;
  assign a_gt   = differ & (a_bit ^ invert_sense);

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator with early exit on the first differing bit.
// Result flags are one-hot and held until the next accepted start.
module serial_mag_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             a_e_b,
  output logic             a_l_b,
  output logic             a_g_b
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] IDX_MSB = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [2:0]       flags_q, flags_d;
  logic             done_q, done_d;

  logic sel_a_bit;
  logic sel_b_bit;
  logic invert_sense;
  logic bit_differ;
  logic bit_a_gt;

  assign sel_a_bit    = a_q[idx_q];
  assign sel_b_bit    = b_q[idx_q];
  // Only the sign bit of a signed compare has inverted weight.
  assign invert_sense = signed_q && (idx_q == IDX_MSB);

  cmp_bit_slice u_slice (
    .a_bit        (sel_a_bit),
    .b_bit        (sel_b_bit),
    .invert_sense (invert_sense),
    .differ       (bit_differ),
    .a_gt         (bit_a_gt)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    idx_d    = idx_q;
    flags_d  = flags_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          a_d      = a_in;
          b_d      = b_in;
          signed_d = signed_in;
          idx_d    = IDX_MSB;
          flags_d  = RES_NONE;
          state_d  = ST_CMP;
        end
      end

      ST_CMP: begin
        if (bit_differ) begin
          flags_d = bit_a_gt ? RES_GT : RES_LT;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (idx_q == '0) begin
          flags_d = RES_EQ;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q - CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
      flags_q  <= RES_NONE;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      idx_q    <= idx_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign busy_out              = (state_q == ST_CMP);
  assign done_out              = done_q;
  assign {a_e_b, a_l_b, a_g_b} = flags_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator (WIDTH=8): directed cases plus
// random compares checked against an arithmetic reference model.
module tb_serial_mag_comparator;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start_in;
  logic             signed_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy_out;
  logic             done_out;
  logic             a_e_b;
  logic             a_l_b;
  logic             a_g_b;

  int pass_cnt  = 0;
  int check_cnt = 0;

  serial_mag_comparator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_in  (start_in),
    .signed_in (signed_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .a_e_b     (a_e_b),
    .a_l_b     (a_l_b),
    .a_g_b     (a_g_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector is {busy, done, eq, lt, gt}.
  task automatic checkOutput(input string tag, input logic [4:0] expected);
    logic [4:0] observed;
    observed  = {busy_out, done_out, a_e_b, a_l_b, a_g_b};
    check_cnt = check_cnt + 1;
    assert (observed === expected) pass_cnt = pass_cnt + 1;
    else $error("[TB] FAIL %s: observed {busy,done,e,l,g}=%b expected %b", tag, observed, expected);
  endtask

  // Reference: plain integer comparison and position of the highest differing bit.
  function automatic logic [2:0] modelResult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic sgn);
    int av;
    int bv;
    av = sgn ? int'($signed(a)) : int'(a);
    bv = sgn ? int'($signed(b)) : int'(b);
    if (av == bv) return 3'b100;
    if (av < bv)  return 3'b010;
    return 3'b001;
  endfunction

  function automatic int modelLatency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x;
    int k;
    x = a ^ b;
    k = WIDTH;
    for (int i = 0; i < WIDTH; i++) if (x[i]) k = WIDTH - i;
    return k;
  endfunction

  // Starts one compare at the next rising edge and checks every cycle through done.
  // With jam_start, start stays high with junk operands through the decision edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic sgn, input bit jam_start, input string tag);
    logic [2:0] res;
    int k;
    res = modelResult(a, b, sgn);
    k   = modelLatency(a, b);
    @(negedge clk);
    start_in  = 1'b1;
    a_in      = a;
    b_in      = b;
    signed_in = sgn;
    @(posedge clk); #1;
    checkOutput({tag, "_accept"}, 5'b10000);
    for (int j = 1; j <= k; j++) begin
      @(negedge clk);
      start_in  = jam_start;
      a_in      = WIDTH'($urandom);
      b_in      = WIDTH'($urandom);
      signed_in = 1'($urandom);
      @(posedge clk); #1;
      if (j < k) checkOutput({tag, "_busy"}, 5'b10000);
      else       checkOutput({tag, "_done"}, {2'b01, res});
    end
  endtask

  task automatic idleCheck(input logic [2:0] held, input string tag);
    @(negedge clk);
    start_in = 1'b0;
    a_in     = WIDTH'($urandom);
    b_in     = WIDTH'($urandom);
    @(posedge clk); #1;
    checkOutput({tag, "_hold"}, {2'b00, held});
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rs;
    rst_n     = 1'b0;
    start_in  = 1'b0;
    signed_in = 1'b0;
    a_in      = '0;
    b_in      = '0;
    #1;
    checkOutput("reset_async", 5'b00000);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_held", 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'h5A, 8'h5A, 1'b0, 1'b0, "equal");
    idleCheck(3'b100, "equal");
    applyStimulus(8'h80, 8'h7F, 1'b0, 1'b0, "early_uns");
    idleCheck(3'b001, "early_uns");
    applyStimulus(8'h80, 8'h7F, 1'b1, 1'b0, "early_sgn");
    idleCheck(3'b010, "early_sgn");
    applyStimulus(8'h12, 8'h13, 1'b0, 1'b0, "lsb_uns");
    applyStimulus(8'hFE, 8'hFD, 1'b1, 1'b0, "lsb_sgn");
    idleCheck(3'b001, "lsb_sgn");

    // Start held during busy is ignored; the back-to-back start at E3 is accepted.
    applyStimulus(8'h40, 8'h00, 1'b0, 1'b1, "hs_first");
    applyStimulus(8'h03, 8'h05, 1'b0, 1'b0, "hs_second");
    idleCheck(3'b010, "hs_second");

    // Reset in the middle of a compare aborts without a done pulse.
    @(negedge clk);
    start_in = 1'b1;
    a_in     = 8'h01;
    b_in     = 8'h01;
    @(posedge clk);
    @(negedge clk);
    start_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_async", 5'b00000);
    @(posedge clk); #1;
    checkOutput("midreset_held", 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset_idle", 5'b00000);
    applyStimulus(8'h7F, 8'h80, 1'b1, 1'b0, "post_reset");

    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
      rs = 1'($urandom);
      applyStimulus(ra, rb, rs, 1'($urandom), "random");
      if ($urandom_range(0, 1) == 1) idleCheck(modelResult(ra, rb, rs), "random");
    end

    @(negedge clk);
    start_in = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
